// File: rtl/sn74ls393_pkg.sv
// LS-family default propagation delays, shared by the ripple counter models.
package sn74ls393_pkg;
  localparam int TTL_LS_TPD_STAGE = 10;
  localparam int TTL_LS_TPD_CLR   = 24;
endpackage

// File: rtl/sn74ls393_tff.sv
// Negative-edge toggle stage with asynchronous active-high clear.
// Only a clean 1->0 on clk counts; clr rising cancels every toggle still in flight.
module sn74ls393_tff
  import sn74ls393_pkg::*;
#(
  parameter int TPD_STAGE = TTL_LS_TPD_STAGE,
  parameter int TPD_CLR   = TTL_LS_TPD_CLR
) (
  input  logic clk,
  input  logic clr,
  output logic q
);
  timeunit 1ns;
  timeprecision 100ps;

  logic        state;
  logic        q_r;
  logic        clk_prev;
  logic        clr_prev;
  int unsigned tog_gen;
  int unsigned clr_gen;

  assign q = q_r;

  // Pending events carry the generation they were issued in and are dropped
  // if a later clear (or, for a clear, a later toggle) has superseded them.
  always @(clk or clr) begin
    if (clr === 1'b1 && clr_prev !== 1'b1) begin
      automatic int unsigned g;
      tog_gen = tog_gen + 1;
      clr_gen = clr_gen + 1;
      state   = 1'b0;
      g       = clr_gen;
      fork
        begin
          #(TPD_CLR);
          if (g == clr_gen) q_r = 1'b0;
        end
      join_none
    end
    if (clk === 1'b0 && clk_prev === 1'b1 && clr !== 1'b1) begin
      automatic int unsigned g;
      automatic logic        v;
      state   = ~state;
      clr_gen = clr_gen + 1;
      g       = tog_gen;
      v       = state;
      fork
        begin
          #(TPD_STAGE);
          if (g == tog_gen) q_r = v;
        end
      join_none
    end
    clk_prev = clk;
    clr_prev = clr;
  end
endmodule

// File: rtl/sn74ls393.sv
// One section of the 74LS393: 4-bit binary ripple counter, asynchronous clear.
// Each stage is clocked by the previous stage's delayed output, so transients are real.
module sn74ls393
  import sn74ls393_pkg::*;
#(
  parameter int TPD_STAGE = TTL_LS_TPD_STAGE,
  parameter int TPD_CLR   = TTL_LS_TPD_CLR
) (
  input  logic       clk,
  input  logic       clr,
  output logic [3:0] q
);
  timeunit 1ns;
  timeprecision 100ps;

  logic [3:0] stage_clk;

  assign stage_clk = {q[2:0], clk};

  for (genvar i = 0; i < 4; i++) begin : g_stage
    sn74ls393_tff #(
      .TPD_STAGE(TPD_STAGE),
      .TPD_CLR  (TPD_CLR)
    ) u_tff (
      .clk(stage_clk[i]),
      .clr(clr),
      .q  (q[i])
    );
  end
endmodule

// File: tb/tb_sn74ls393.sv
// Bench for the 74LS393 section: count table, exact ripple transients, clear corner cases, random runs.
module tb_sn74ls393;
  timeunit 1ns;
  timeprecision 100ps;

  logic       clk;
  logic       clr;
  logic [3:0] q;

  int total;
  int bad;
  int model;

  typedef struct {
    int         falls;
    logic [3:0] exp;
  } vec_t;

  vec_t vec[16];

  sn74ls393 dut (
    .clk(clk),
    .clr(clr),
    .q  (q)
  );

  task automatic check(input string name, input logic [3:0] exp);
    total++;
    if (q !== exp) begin
      bad++;
      $display("FAIL %s at %0t: q=%0d expected=%0d", name, $time, q, exp);
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    #30;
    clr = 1'b0;
    #10;
    model = 0;
  endtask

  task automatic pulses(input int n, input real half);
    for (int i = 0; i < n; i++) begin
      clk = 1'b0;
      #(half);
      clk = 1'b1;
      #(half);
    end
    model = (model + n) % 16;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model = 0;
    clk   = 1'b1;
    clr   = 1'b0;

    for (int i = 0; i < 16; i++) begin
      vec[i].falls = i + 1;
      vec[i].exp   = 4'((i + 1) % 16);
    end

    #20;
    do_clear();
    check("reset", 4'd0);

    // 1: 16 falls at 100 ns, sampled 50 ns after each edge
    for (int i = 0; i < 16; i++) begin
      clk = 1'b0;
      #50;
      check($sformatf("count_%0d", vec[i].falls), vec[i].exp);
      clk = 1'b1;
      #50;
    end

    // 2: 7 -> 8 transients
    do_clear();
    pulses(7, 50.0);
    check("pre7", 4'd7);
    clk = 1'b0;
    #9.5  check("r7_hold", 4'd7);
    #1.0  check("r7_10", 4'd6);
    #10.0 check("r7_20", 4'd4);
    #10.0 check("r7_30", 4'd0);
    #10.0 check("r7_40", 4'd8);
    #39.5 clk = 1'b1;
    #50;

    // 3: 15 -> 0 transients
    pulses(7, 50.0);
    check("pre15", 4'd15);
    clk = 1'b0;
    #10.5 check("r15_10", 4'd14);
    #10.0 check("r15_20", 4'd12);
    #10.0 check("r15_30", 4'd8);
    #10.0 check("r15_40", 4'd0);
    #39.5 clk = 1'b1;
    #50;

    // 4: clear 15 ns into the 7 -> 8 ripple
    do_clear();
    pulses(7, 50.0);
    clk = 1'b0;
    #15 clr = 1'b1;
    #23.5 check("midclr_before", 4'd6);
    #1.0  check("midclr_after", 4'd0);
    #20.5 clk = 1'b1;
    #20 clk = 1'b0;
    #20 clk = 1'b1;
    #20 clk = 1'b0;
    #100 check("midclr_hold", 4'd0);
    clk = 1'b1;
    #10 clr = 1'b0;
    #20;
    model = 0;
    pulses(1, 50.0);
    check("midclr_resume", 4'd1);

    // 5: clr rising coincident with clk falling, both orderings
    for (int k = 0; k < 2; k++) begin
      pulses(3, 50.0);
      if (k == 0) begin
        clr = 1'b1;
        clk = 1'b0;
      end else begin
        clk = 1'b0;
        clr = 1'b1;
      end
      #50 check($sformatf("coinc_%0d", k), 4'd0);
      clk = 1'b1;
      #10 clr = 1'b0;
      #10 clk = 1'b0;
      #50 check($sformatf("coinc_clean_%0d", k), 4'd1);
      clk = 1'b1;
      #50;
      model = 1;
    end

    // 6: 25 ns clock, faster than the full ripple
    do_clear();
    pulses(20, 12.5);
    #60 check("fast25", 4'd4);

    // random runs against the count-mod-16 rule
    do_clear();
    for (int r = 0; r < 12; r++) begin
      int nf;
      int half;
      nf   = $urandom_range(1, 20);
      half = $urandom_range(13, 60);
      if ($urandom_range(0, 3) == 0) do_clear();
      pulses(nf, real'(half));
      #60 check($sformatf("rand_%0d", r), 4'(model));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
